// File: rtl/fp_wb_collector_if.sv
// Writeback collector bus: per-unit result inputs, pipeline enables and
// the shared registered writeback port.
interface fp_wb_collector_if #(
    parameter int unsigned NUM_UNITS = 4
);
    logic [NUM_UNITS-1:0]       unit_valid_i;
    logic [NUM_UNITS-1:0][31:0] unit_result_i;
    logic [NUM_UNITS-1:0][4:0]  unit_rd_i;
    logic [NUM_UNITS-1:0]       unit_fp_we_i;
    logic [NUM_UNITS-1:0]       unit_int_we_i;
    logic [NUM_UNITS-1:0]       unit_en_o;
    logic                       flush_i;
    logic                       wb_ready_i;
    logic                       wb_valid_o;
    logic [31:0]                wb_data_o;
    logic [4:0]                 wb_rd_o;
    logic                       wb_fp_we_o;
    logic                       wb_int_we_o;
    logic [2:0]                 wb_unit_o;
    logic                       busy_o;

    // Collector side
    modport slave (
        input  unit_valid_i, unit_result_i, unit_rd_i, unit_fp_we_i, unit_int_we_i,
        input  flush_i, wb_ready_i,
        output unit_en_o, wb_valid_o, wb_data_o, wb_rd_o, wb_fp_we_o, wb_int_we_o,
        output wb_unit_o, busy_o
    );

    // FP units / register-file side
    modport master (
        output unit_valid_i, unit_result_i, unit_rd_i, unit_fp_we_i, unit_int_we_i,
        output flush_i, wb_ready_i,
        input  unit_en_o, wb_valid_o, wb_data_o, wb_rd_o, wb_fp_we_o, wb_int_we_o,
        input  wb_unit_o, busy_o
    );
endinterface

// File: rtl/fp_wb_collector.sv
// FP writeback collector: per-unit result FIFOs, round-robin arbitration
// into one registered writeback port, per-unit freeze enables and flush.
// Optional feature macro: FP_WB_BYPASS_EN (empty FIFO with a captured input
// may go straight to the output register in the capture cycle).
module fp_wb_collector #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    fp_wb_collector_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned UW = $clog2(NUM_UNITS);
    localparam int unsigned EW = 39;

    // FIFO storage and bookkeeping
    logic [EW-1:0]        r_mem  [NUM_UNITS][DEPTH];
    logic [PW-1:0]        r_wptr [NUM_UNITS];
    logic [PW-1:0]        r_rptr [NUM_UNITS];
    logic [CW-1:0]        r_cnt  [NUM_UNITS];
    logic [NUM_UNITS-1:0] r_en;
    logic [UW-1:0]        r_rr;

    // Output register
    logic                 r_valid;
    logic [31:0]          r_data;
    logic [4:0]           r_rd;
    logic                 r_fp_we;
    logic                 r_int_we;
    logic [2:0]           r_unit;
    logic                 r_busy;

    logic [EW-1:0]        w_in     [NUM_UNITS];
    logic [CW-1:0]        w_cnt_nx [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_cap;
    logic [NUM_UNITS-1:0] w_req;
    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic                 w_load;
    logic                 w_any;
    logic                 w_byp;
    logic [UW-1:0]        w_gnt;
    logic [EW-1:0]        w_sel;
    logic                 w_valid_nx;
    logic                 w_busy_nx;
    int unsigned          w_idx;

    // Capture qualification, round-robin grant, push/pop decode, next counts
    always_comb begin
        w_load     = !r_valid | bus.wb_ready_i;
        w_any      = 1'b0;
        w_gnt      = '0;
        w_idx      = 0;
        w_byp      = 1'b0;
        w_busy_nx  = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_in[i]  = {bus.unit_result_i[i], bus.unit_rd_i[i],
                        bus.unit_fp_we_i[i], bus.unit_int_we_i[i]};
            w_cap[i] = bus.unit_valid_i[i] & r_en[i];
`ifdef FP_WB_BYPASS_EN
            w_req[i] = (r_cnt[i] != '0) | w_cap[i];
`else
            w_req[i] = (r_cnt[i] != '0);
`endif
        end
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            w_idx = (32'(r_rr) + k) % NUM_UNITS;
            if (!w_any && w_req[UW'(w_idx)]) begin
                w_any = 1'b1;
                w_gnt = UW'(w_idx);
            end
        end
`ifdef FP_WB_BYPASS_EN
        // Granted unit with an empty FIFO can only be a bypass request
        w_byp = w_load & w_any & (r_cnt[w_gnt] == '0);
`endif
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_pop[i]    = w_load & w_any & (w_gnt == UW'(i)) & (r_cnt[i] != '0);
            w_push[i]   = w_cap[i] & !(w_byp & (w_gnt == UW'(i)));
            w_cnt_nx[i] = r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        end
        w_sel      = w_byp ? w_in[w_gnt] : r_mem[w_gnt][r_rptr[w_gnt]];
        w_valid_nx = w_load ? w_any : r_valid;
        w_busy_nx  = w_valid_nx;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_cnt_nx[i] != '0) begin
                w_busy_nx = 1'b1;
            end
        end
    end

    // FIFO data array write (flush discards the same-cycle capture)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_push[i] && !bus.flush_i) begin
                r_mem[i][r_wptr[i]] <= w_in[i];
            end
        end
    end

    // FIFO pointers/counts, enables, arbitration pointer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_en     <= '1;
            r_rr     <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_rd     <= '0;
            r_fp_we  <= 1'b0;
            r_int_we <= 1'b0;
            r_unit   <= '0;
            r_busy   <= 1'b0;
        end else if (bus.flush_i) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_en     <= '1;
            r_valid  <= 1'b0;
            r_fp_we  <= 1'b0;
            r_int_we <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                end
                r_cnt[i] <= w_cnt_nx[i];
                r_en[i]  <= (w_cnt_nx[i] != CW'(DEPTH));
            end
            r_busy <= w_busy_nx;
            if (w_load) begin
                if (w_any) begin
                    r_valid  <= 1'b1;
                    r_data   <= w_sel[38:7];
                    r_rd     <= w_sel[6:2];
                    r_fp_we  <= w_sel[1];
                    r_int_we <= w_sel[0];
                    r_unit   <= 3'(w_gnt);
                    r_rr     <= (w_gnt == UW'(NUM_UNITS - 1)) ? '0 : w_gnt + UW'(1);
                end else begin
                    r_valid  <= 1'b0;
                    r_fp_we  <= 1'b0;
                    r_int_we <= 1'b0;
                end
            end
        end
    end

    assign bus.unit_en_o   = r_en;
    assign bus.wb_valid_o  = r_valid;
    assign bus.wb_data_o   = r_data;
    assign bus.wb_rd_o     = r_rd;
    assign bus.wb_fp_we_o  = r_fp_we;
    assign bus.wb_int_we_o = r_int_we;
    assign bus.wb_unit_o   = r_unit;
    assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_fp_wb_collector.sv
// Bench for fp_wb_collector: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Honors FP_WB_BYPASS_EN for the expected latency.
module tb_fp_wb_collector;
    localparam int NU  = 4;
    localparam int DEP = 2;
`ifdef FP_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        fp;
        logic        in;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    fp_wb_collector_if #(.NUM_UNITS(NU)) bus ();
    fp_wb_collector #(.NUM_UNITS(NU), .DEPTH(DEP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq [NU][$];
    ent_t        pend [NU];
    bit          pv [NU];
    logic        m_ov, m_fp, m_in;
    logic [31:0] m_d;
    logic [4:0]  m_rd;
    logic [2:0]  m_unit;
    int          m_rr;

    int          vectors;
    int          miscompares;
    logic [31:0] log_d [$];
    int          log_u [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NU; i++) begin
            mq[i].delete();
            pv[i]   = 1'b0;
            pend[i] = '0;
        end
        m_ov = 1'b0; m_fp = 1'b0; m_in = 1'b0;
        m_d = '0; m_rd = '0; m_unit = '0; m_rr = 0;
    endtask

    // One clock edge of the collector's behaviour, from the rules
    task automatic model_step();
        bit   cap [NU];
        ent_t inp [NU];
        ent_t e;
        int   g;
        int   u;
        bit   got, load, byp;
        for (int i = 0; i < NU; i++) begin
            inp[i] = {bus.unit_result_i[i], bus.unit_rd_i[i], bus.unit_fp_we_i[i], bus.unit_int_we_i[i]};
            cap[i] = bus.unit_valid_i[i] && (mq[i].size() < DEP);
        end
        if (bus.flush_i) begin
            for (int i = 0; i < NU; i++) begin
                if (cap[i]) pv[i] = 1'b0;
                mq[i].delete();
            end
            m_ov = 1'b0; m_fp = 1'b0; m_in = 1'b0;
            return;
        end
        load = !m_ov || bus.wb_ready_i;
        got = 1'b0; byp = 1'b0; g = 0; e = '0;
        if (load) begin
            for (int k = 0; k < NU; k++) begin
                u = (m_rr + k) % NU;
                if (!got && (mq[u].size() > 0 || (BYP && cap[u]))) begin
                    got = 1'b1;
                    g   = u;
                end
            end
        end
        if (got) begin
            if (mq[g].size() > 0) e = mq[g].pop_front();
            else begin
                e   = inp[g];
                byp = 1'b1;
            end
            m_ov = 1'b1; m_d = e.d; m_rd = e.rd; m_fp = e.fp; m_in = e.in;
            m_unit = 3'(g);
            m_rr = (g + 1) % NU;
        end else if (load) begin
            m_ov = 1'b0; m_fp = 1'b0; m_in = 1'b0;
        end
        for (int i = 0; i < NU; i++) begin
            if (cap[i]) begin
                if (!(byp && g == i)) mq[i].push_back(inp[i]);
                pv[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NU-1:0] en;
        bit busy;
        busy = m_ov;
        for (int i = 0; i < NU; i++) begin
            en[i] = (mq[i].size() < DEP);
            if (mq[i].size() > 0) busy = 1'b1;
        end
        check("wb_valid", 64'(bus.wb_valid_o), 64'(m_ov));
        check("wb_data", 64'(bus.wb_data_o), 64'(m_d));
        check("wb_rd", 64'(bus.wb_rd_o), 64'(m_rd));
        check("wb_fp_we", 64'(bus.wb_fp_we_o), 64'(m_fp));
        check("wb_int_we", 64'(bus.wb_int_we_o), 64'(m_in));
        check("wb_unit", 64'(bus.wb_unit_o), 64'(m_unit));
        check("unit_en", 64'(bus.unit_en_o), 64'(en));
        check("busy", 64'(bus.busy_o), 64'(busy));
    endtask

    // Units hold a pending result until it is captured
    task automatic drive();
        for (int i = 0; i < NU; i++) begin
            bus.unit_valid_i[i]  = pv[i];
            bus.unit_result_i[i] = pend[i].d;
            bus.unit_rd_i[i]     = pend[i].rd;
            bus.unit_fp_we_i[i]  = pend[i].fp;
            bus.unit_int_we_i[i] = pend[i].in;
        end
    endtask

    task automatic post(input int u, input logic [31:0] d, input logic [4:0] rd,
                        input logic fp, input logic in);
        pend[u] = '{d: d, rd: rd, fp: fp, in: in};
        pv[u]   = 1'b1;
    endtask

    // Called at a falling edge: drive, log acceptance, step model, compare
    task automatic cycle();
        drive();
        if (bus.wb_valid_o && bus.wb_ready_i) begin
            log_d.push_back(bus.wb_data_o);
            log_u.push_back(int'(bus.wb_unit_o));
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(bus.wb_valid_o), 64'(0));
        check({tag, "_data"}, 64'(bus.wb_data_o), 64'(0));
        check({tag, "_rd"}, 64'(bus.wb_rd_o), 64'(0));
        check({tag, "_unit"}, 64'(bus.wb_unit_o), 64'(0));
        check({tag, "_we"}, 64'({bus.wb_fp_we_o, bus.wb_int_we_o}), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
        check({tag, "_en"}, 64'(bus.unit_en_o), 64'(4'b1111));
    endtask

    task automatic do_reset(input bit check_now);
        rst = 1'b1;
        #1;
        if (check_now) check_reset_values("rst_mid");
        model_reset();
        bus.flush_i = 1'b0;
        drive();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.wb_ready_i = 1'b0;
        model_reset();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        check_reset_values("reset");

        // Single result from unit 1
        bus.wb_ready_i = 1'b1;
        post(1, 32'h3F80_0000, 5'd5, 1'b1, 1'b0);
        cycle();
        if (!BYP) begin
            check("single_early_valid", 64'(bus.wb_valid_o), 64'(0));
            cycle();
        end
        check("single_valid", 64'(bus.wb_valid_o), 64'(1));
        check("single_data", 64'(bus.wb_data_o), 64'(32'h3F80_0000));
        check("single_rd", 64'(bus.wb_rd_o), 64'(5));
        check("single_unit", 64'(bus.wb_unit_o), 64'(1));
        check("single_fp_we", 64'(bus.wb_fp_we_o), 64'(1));
        cycle();
        cycle();

        // Round-robin from rr_ptr = 0
        do_reset(1'b0);
        bus.wb_ready_i = 1'b1;
        for (int u = 0; u < NU; u++) post(u, 32'hA000_0000 + 32'(u), 5'(u), 1'b1, 1'b0);
        log_d.delete(); log_u.delete();
        repeat (6) cycle();
        check("rr_count", 64'(log_u.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < log_u.size()) begin
                check("rr_unit", 64'(log_u[k]), 64'(k));
                check("rr_data", 64'(log_d[k]), 64'(32'hA000_0000 + 32'(k)));
            end
        end
        check("rr_busy_low", 64'(bus.busy_o), 64'(0));

        // Back-pressure on unit 2
        do_reset(1'b0);
        bus.wb_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            post(2, 32'hB000_0000 + 32'(k), 5'(10 + k), 1'b0, 1'b1);
            cycle();
            if (k == 2) check("bp_en_low", 64'(bus.unit_en_o[2]), 64'(0));
        end
        repeat (2) cycle();
        check("bp_en_still_low", 64'(bus.unit_en_o[2]), 64'(0));
        check("bp_held_at_unit", 64'(bus.unit_valid_i[2]), 64'(1));
        bus.wb_ready_i = 1'b1;
        log_d.delete(); log_u.delete();
        repeat (8) cycle();
        check("bp_count", 64'(log_d.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < log_d.size()) begin
                check("bp_order", 64'(log_d[k]), 64'(32'hB000_0000 + 32'(k)));
                check("bp_unit", 64'(log_u[k]), 64'(2));
            end
        end

        // Hold stability
        do_reset(1'b0);
        bus.wb_ready_i = 1'b0;
        post(3, 32'hC0FF_EE00, 5'd7, 1'b0, 1'b1);
        repeat (3) cycle();
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", 64'(bus.wb_valid_o), 64'(1));
            check("hold_data", 64'(bus.wb_data_o), 64'(32'hC0FF_EE00));
            check("hold_rd_unit", 64'({bus.wb_rd_o, bus.wb_unit_o}), 64'({5'd7, 3'd3}));
            check("hold_we", 64'({bus.wb_fp_we_o, bus.wb_int_we_o}), 64'(2'b01));
            cycle();
        end
        bus.wb_ready_i = 1'b1;
        log_d.delete(); log_u.delete();
        cycle();
        check("hold_accept_n", 64'(log_d.size()), 64'(1));
        if (log_d.size() > 0) check("hold_accept_d", 64'(log_d[0]), 64'(32'hC0FF_EE00));

        // Flush with a same-cycle capture
        do_reset(1'b0);
        bus.wb_ready_i = 1'b0;
        for (int u = 0; u < NU; u++) post(u, 32'hD000_0000 + 32'(u), 5'(u), 1'b1, 1'b0);
        cycle();
        for (int u = 1; u < NU; u++) post(u, 32'hD100_0000 + 32'(u), 5'(u), 1'b1, 1'b0);
        cycle();
        post(0, 32'hDEAD_0000, 5'd1, 1'b1, 1'b0);
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        check("flush_valid", 64'(bus.wb_valid_o), 64'(0));
        check("flush_busy", 64'(bus.busy_o), 64'(0));
        check("flush_en", 64'(bus.unit_en_o), 64'(4'b1111));
        bus.wb_ready_i = 1'b1;
        log_d.delete(); log_u.delete();
        repeat (5) cycle();
        check("flush_nothing_written", 64'(log_d.size()), 64'(0));

        // Reset in the middle of traffic
        do_reset(1'b0);
        bus.wb_ready_i = 1'b0;
        for (int u = 0; u < NU; u++) post(u, 32'hE000_0000 + 32'(u), 5'(u), 1'b0, 1'b1);
        cycle();
        cycle();
        check("pre_rst_valid", 64'(bus.wb_valid_o), 64'(1));
        do_reset(1'b1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int rate;
            rate = ((c / 400) % 2 == 0) ? 80 : 25;
            bus.wb_ready_i = ($urandom % 100) < ((c / 700) % 2 == 0 ? 70 : 30);
            bus.flush_i    = ($urandom % 100) < 2;
            for (int u = 0; u < NU; u++) begin
                if (!pv[u] && int'($urandom % 100) < rate)
                    post(u, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            end
            cycle();
        end
        bus.flush_i = 1'b0;
        bus.wb_ready_i = 1'b1;
        repeat (12) cycle();
        check("final_busy", 64'(bus.busy_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
